// File: rtl/record_gate.sv
// Purpose: trigger-gated record capture; writes fixed-length records of valid words into the acquisition FIFO.
// Latency: one cycle from an accepted input word to data_o / wr_en_o / record_start_o / record_end_o / trig_pos_o.
// Backpressure: a capture word arriving with fifo_full_i high is dropped (no write), still counts, and sets sticky overflow_o.
module record_gate #(
  parameter int NofBits = 16,
  parameter int LenBits = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm_i,
  input  logic [LenBits-1:0]   record_len_i,
  input  logic [LenBits-1:0]   nof_records_i,
  input  logic [NofBits-1:0]   x0_i,
  input  logic [NofBits-1:0]   x0z_i,
  input  logic [NofBits-1:0]   x1_i,
  input  logic [NofBits-1:0]   x1z_i,
  input  logic                 data_valid_i,
  input  logic [3:0]           trigger_vector_i,
  input  logic                 active_i,
  input  logic                 fifo_full_i,
  output logic                 wr_en_o,
  output logic [4*NofBits-1:0] data_o,
  output logic                 record_start_o,
  output logic                 record_end_o,
  output logic [1:0]           trig_pos_o,
  output logic [LenBits-1:0]   record_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Latched acquisition geometry (zero is promoted to one at arm time).
  logic [LenBits-1:0] len_q;
  logic [LenBits-1:0] nof_q;
  logic [LenBits-1:0] len_m1;
  logic [LenBits-1:0] nof_m1;
  // Index of the word about to be accepted within the current record.
  logic [LenBits-1:0] word_cnt;

  logic       arm_go;
  logic       trig_hit;
  logic       take;
  logic       last;
  logic       final_rec;
  logic [1:0] trig_lsb;

  assign len_m1    = len_q - 1'b1;
  assign nof_m1    = nof_q - 1'b1;
  assign arm_go    = (state == IDLE) && arm_i;
  // A qualified trigger is only honoured while waiting for a record to start.
  assign trig_hit  = (state == ARMED) && data_valid_i && active_i && (|trigger_vector_i);
  // Every valid cycle inside a record is a record word, regardless of active_i.
  assign take      = trig_hit || ((state == CAPTURE) && data_valid_i);
  // word_cnt is held at zero in ARMED, so this also covers length-1 records.
  assign last      = take && (word_cnt == len_m1);
  assign final_rec = (record_cnt_o == nof_m1);
  assign busy_o    = (state == ARMED) || (state == CAPTURE);

  // Lowest set trigger bit index.
  always_comb begin
    trig_lsb = 2'd0;
    if (trigger_vector_i[0])      trig_lsb = 2'd0;
    else if (trigger_vector_i[1]) trig_lsb = 2'd1;
    else if (trigger_vector_i[2]) trig_lsb = 2'd2;
    else if (trigger_vector_i[3]) trig_lsb = 2'd3;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a record closes on its last word, back to ARMED or on to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (arm_i) state_next = ARMED;
      end
      ARMED: begin
        if (trig_hit) begin
          if (last) state_next = final_rec ? DONE : ARMED;
          else      state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (last) state_next = final_rec ? DONE : ARMED;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Geometry latch, word counter and completed-record counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      nof_q        <= '0;
      word_cnt     <= '0;
      record_cnt_o <= '0;
    end else if (arm_go) begin
      len_q        <= (record_len_i  == '0) ? LenBits'(1) : record_len_i;
      nof_q        <= (nof_records_i == '0) ? LenBits'(1) : nof_records_i;
      word_cnt     <= '0;
      record_cnt_o <= '0;
    end else if (take) begin
      if (last) begin
        word_cnt <= '0;
        if (record_cnt_o != nof_q) record_cnt_o <= record_cnt_o + 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow: set by any dropped capture word, cleared only by a new arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (arm_go) begin
      overflow_o <= 1'b0;
    end else if (take && fifo_full_i) begin
      overflow_o <= 1'b1;
    end
  end

  // Registered FIFO-side outputs; data_o only moves on an actual write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_o        <= 1'b0;
      data_o         <= '0;
      record_start_o <= 1'b0;
      record_end_o   <= 1'b0;
      trig_pos_o     <= 2'd0;
      done_o         <= 1'b0;
    end else begin
      wr_en_o        <= take && !fifo_full_i;
      record_start_o <= trig_hit;
      record_end_o   <= last;
      done_o         <= (state == DONE);
      if (take && !fifo_full_i) data_o <= {x1z_i, x1_i, x0z_i, x0_i};
      if (trig_hit) trig_pos_o <= trig_lsb;
    end
  end

endmodule

// File: tb/tb_record_gate.sv
// Directed bench for record_gate: arm/trigger/capture sequences with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; registered outputs are checked at the same point.
// Covers reset, multi-record runs, ignored triggers, FIFO-full drops, zero geometry and async reset.
module tb_record_gate;

  logic        clk;
  logic        rst_n;
  logic        arm_i;
  logic [15:0] record_len_i;
  logic [15:0] nof_records_i;
  logic [15:0] x0_i, x0z_i, x1_i, x1z_i;
  logic        data_valid_i;
  logic [3:0]  trigger_vector_i;
  logic        active_i;
  logic        fifo_full_i;
  logic        wr_en_o;
  logic [63:0] data_o;
  logic        record_start_o;
  logic        record_end_o;
  logic [1:0]  trig_pos_o;
  logic [15:0] record_cnt_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  record_gate #(.NofBits(16), .LenBits(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arm_i            (arm_i),
    .record_len_i     (record_len_i),
    .nof_records_i    (nof_records_i),
    .x0_i             (x0_i),
    .x0z_i            (x0z_i),
    .x1_i             (x1_i),
    .x1z_i            (x1z_i),
    .data_valid_i     (data_valid_i),
    .trigger_vector_i (trigger_vector_i),
    .active_i         (active_i),
    .fifo_full_i      (fifo_full_i),
    .wr_en_o          (wr_en_o),
    .data_o           (data_o),
    .record_start_o   (record_start_o),
    .record_end_o     (record_end_o),
    .trig_pos_o       (trig_pos_o),
    .record_cnt_o     (record_cnt_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .overflow_o       (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed word for samples base, base+1, base+2, base+3 as {x1z, x1, x0z, x0}.
  function automatic logic [63:0] word(input logic [15:0] b);
    logic [15:0] b1, b2, b3;
    b1 = b + 16'd1;
    b2 = b + 16'd2;
    b3 = b + 16'd3;
    return {b3, b2, b1, b};
  endfunction

  // Present one input cycle, then land 1 time unit after the capturing edge.
  task automatic cyc(input logic v, input logic [3:0] t, input logic a, input logic f, input logic [15:0] b);
    data_valid_i     = v;
    trigger_vector_i = t;
    active_i         = a;
    fifo_full_i      = f;
    x0_i  = b;
    x0z_i = b + 16'd1;
    x1_i  = b + 16'd2;
    x1z_i = b + 16'd3;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] len, input logic [15:0] nof);
    arm_i         = 1'b1;
    record_len_i  = len;
    nof_records_i = nof;
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    arm_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm_i = 1'b0; record_len_i = '0; nof_records_i = '0;
    x0_i = '0; x0z_i = '0; x1_i = '0; x1z_i = '0;
    data_valid_i = 1'b0; trigger_vector_i = '0; active_i = 1'b0; fifo_full_i = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", wr_en_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", record_cnt_o, 0);
    chk("rst_flags", {record_start_o, record_end_o, done_o, overflow_o, trig_pos_o}, 0);
    rst_n = 1'b1;
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);

    // len=4, records=1, valid every cycle, trigger on the 3rd valid.
    do_arm(16'd4, 16'd1);
    chk("t1_busy_after_arm", busy_o, 1);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0001);
    chk("t1_pre_wr1", wr_en_o, 0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0002);
    chk("t1_pre_wr2", wr_en_o, 0);
    cyc(1'b1, 4'b0100, 1'b1, 1'b0, 16'h0010);
    chk("t1_w0_wr", wr_en_o, 1);
    chk("t1_w0_start_end", {record_start_o, record_end_o}, 2'b10);
    chk("t1_trig_pos", trig_pos_o, 2);
    chk("t1_w0_data", data_o, word(16'h0010));
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0020);
    chk("t1_w1_flags", {wr_en_o, record_start_o, record_end_o}, 3'b100);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0030);
    chk("t1_w2_data", data_o, word(16'h0030));
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0040);
    chk("t1_w3_flags", {wr_en_o, record_start_o, record_end_o}, 3'b101);
    chk("t1_w3_data", data_o, word(16'h0040));
    chk("t1_cnt", record_cnt_o, 1);
    chk("t1_busy_in_done", busy_o, 0);
    chk("t1_done_not_yet", done_o, 0);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t1_done", done_o, 1);
    chk("t1_wr_after", wr_en_o, 0);
    chk("t1_data_hold", data_o, word(16'h0040));
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t1_done_pulse", done_o, 0);

    // len=3, records=2, valid every other cycle.
    do_arm(16'd3, 16'd2);
    chk("t2_cnt_cleared", record_cnt_o, 0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 16'h0100);
    chk("t2_r0w0", {wr_en_o, record_start_o, record_end_o}, 3'b110);
    chk("t2_r0_pos", trig_pos_o, 0);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t2_gap0", wr_en_o, 0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0110);
    chk("t2_r0w1", {wr_en_o, record_start_o, record_end_o}, 3'b100);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t2_gap1", wr_en_o, 0);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0120);
    chk("t2_r0w2", {wr_en_o, record_start_o, record_end_o}, 3'b101);
    chk("t2_r0_cnt", record_cnt_o, 1);
    chk("t2_busy_between", busy_o, 1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t2_no_done_mid", done_o, 0);
    cyc(1'b1, 4'b1000, 1'b1, 1'b0, 16'h0200);
    chk("t2_r1w0", {wr_en_o, record_start_o, record_end_o}, 3'b110);
    chk("t2_r1_pos", trig_pos_o, 3);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0210);
    chk("t2_r1w1", data_o, word(16'h0210));
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0220);
    chk("t2_r1w2", {wr_en_o, record_start_o, record_end_o}, 3'b101);
    chk("t2_r1_cnt", record_cnt_o, 2);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t2_done", done_o, 1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t2_done_once", done_o, 0);
    chk("t2_busy_low", busy_o, 0);

    // Ignored triggers: inactive, non-valid, in-capture, and on the last word.
    do_arm(16'd2, 16'd2);
    cyc(1'b1, 4'b0010, 1'b0, 1'b0, 16'h02F0);
    chk("t3_inactive_ign", {wr_en_o, record_start_o, busy_o}, 3'b001);
    cyc(1'b0, 4'b0010, 1'b1, 1'b0, 16'h02F8);
    chk("t3_invalid_ign", {wr_en_o, record_start_o, busy_o}, 3'b001);
    cyc(1'b1, 4'b0110, 1'b1, 1'b0, 16'h0300);
    chk("t3_start", {wr_en_o, record_start_o, record_end_o}, 3'b110);
    chk("t3_pos", trig_pos_o, 1);
    chk("t3_data", data_o, word(16'h0300));
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 16'h0310);
    chk("t3_capture_trig", {wr_en_o, record_start_o, record_end_o}, 3'b101);
    chk("t3_cnt1", record_cnt_o, 1);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0318);
    chk("t3_no_restart", {wr_en_o, record_start_o}, 2'b00);
    cyc(1'b1, 4'b1000, 1'b1, 1'b0, 16'h0320);
    chk("t3_r1_start", {wr_en_o, record_start_o, trig_pos_o}, 4'b1111);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0330);
    chk("t3_r1_end", {record_end_o, record_cnt_o}, {1'b1, 16'd2});
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t3_done", done_o, 1);

    // FIFO full on word 2 of a len=4 record.
    do_arm(16'd4, 16'd1);
    chk("t4_ovf_clear", overflow_o, 0);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 16'h0400);
    chk("t4_w0", {wr_en_o, record_start_o}, 2'b11);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0410);
    chk("t4_w1", wr_en_o, 1);
    cyc(1'b1, 4'b0000, 1'b1, 1'b1, 16'h0420);
    chk("t4_w2_drop", wr_en_o, 0);
    chk("t4_w2_ovf", overflow_o, 1);
    chk("t4_w2_hold", data_o, word(16'h0410));
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0430);
    chk("t4_w3_end", {wr_en_o, record_end_o, overflow_o}, 3'b111);
    chk("t4_cnt", record_cnt_o, 1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t4_done_ovf", {done_o, overflow_o}, 2'b11);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t4_ovf_sticky", overflow_o, 1);

    // len=0, records=0 behave as 1/1; the arm also clears overflow.
    do_arm(16'd0, 16'd0);
    chk("t5_ovf_cleared", overflow_o, 0);
    cyc(1'b1, 4'b0100, 1'b1, 1'b0, 16'h0500);
    chk("t5_start_end", {wr_en_o, record_start_o, record_end_o}, 3'b111);
    chk("t5_pos", trig_pos_o, 2);
    chk("t5_cnt", record_cnt_o, 1);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t5_done", done_o, 1);

    // Asynchronous reset during word 2 of a len=5 record.
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    do_arm(16'd5, 16'd1);
    cyc(1'b1, 4'b0001, 1'b1, 1'b0, 16'h0600);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0610);
    chk("t6_pre_rst", {wr_en_o, busy_o}, 2'b11);
    x0_i = 16'h0620; data_valid_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_wr", wr_en_o, 0);
    chk("t6_async_data", data_o, 0);
    chk("t6_async_busy", busy_o, 0);
    chk("t6_async_flags", {record_start_o, record_end_o, done_o, overflow_o, trig_pos_o, record_cnt_o}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t6_post_quiet", {wr_en_o, done_o, busy_o}, 3'b000);
    do_arm(16'd2, 16'd1);
    cyc(1'b1, 4'b0010, 1'b1, 1'b0, 16'h0700);
    chk("t6_clean_start", {wr_en_o, record_start_o, record_end_o, trig_pos_o}, 5'b11001);
    cyc(1'b1, 4'b0000, 1'b1, 1'b0, 16'h0710);
    chk("t6_clean_end", {wr_en_o, record_end_o, record_cnt_o}, {2'b11, 16'd1});
    chk("t6_clean_data", data_o, word(16'h0710));
    cyc(1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000);
    chk("t6_clean_done", done_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
